lsu_pipe: RTL and testbench
===========================

LSU_PIPE -- requirements
Module: lsu_pipe

Interface
REQ-001 Parameter DATA_W, default 32, data and address width; legal values 32 and 64; byte-lane count NB = DATA_W/8.
REQ-002 Parameter TIMEOUT_CYC, default 16, maximum cycles spent in REQ plus WAIT_RESP before abort; legal range 1..255.
REQ-003 Ports, one per line:
- clock  in  1  single clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high
- lsu_en_ip  in  1  decode marks a memory operation
- lsu_operator_ip  in  load_store_func_code  one of LB, LH, LW, LBU, LHU, SB, SH, SW
- alu_valid_ip  in  1  address valid
- mem_addr_ip  in  DATA_W  byte address
- store_data_ip  in  DATA_W  store source, right-aligned
- data_req_op  out  1  memory request
- data_gnt_ip  in  1  memory accepted the request
- data_addr_op  out  DATA_W  word-aligned address (low log2(NB) bits zero)
- data_we_op  out  1  1 = store
- data_be_op  out  NB  byte enables
- data_wdata_op  out  DATA_W  lane-shifted store data
- data_rvalid_ip  in  1  read data valid
- data_rdata_ip  in  DATA_W  read data
- load_mem_data_op  out  DATA_W  extended load result
- lsu_busy_op  out  1  high in any state except IDLE
- lsu_done_op  out  1  one-cycle completion pulse
- misaligned_op  out  1  one-cycle alignment-fault pulse
- timeout_op  out  1  one-cycle timeout-fault pulse

Function
REQ-004 An operation is accepted when the FSM is in IDLE and lsu_en_ip & alu_valid_ip are high; operator, address and store data are registered on acceptance.
REQ-005 Alignment: halfword operations require addr[0]=0; word operations require addr[1:0]=0; byte operations are always aligned.
REQ-006 A misaligned operation pulses misaligned_op in the following cycle, issues no request and leaves the FSM in IDLE.
REQ-007 FSM states and transitions: IDLE -> REQ on aligned accept; REQ -> IDLE on grant for a store; REQ -> WAIT_RESP on grant for a load; WAIT_RESP -> IDLE on data_rvalid_ip; REQ or WAIT_RESP -> IDLE on timeout.
REQ-008 In REQ, data_req_op, data_addr_op, data_we_op, data_be_op and data_wdata_op are driven from registers and held stable until data_gnt_ip is sampled high.
REQ-009 data_req_op is low in every state except REQ.
REQ-010 Byte enables: SB sets bit addr[1:0]; SH sets 2'b11 shifted left by addr[1]*2; SW sets all four bits (lower four lanes when DATA_W=64, using addr[2] for lane select).
REQ-011 data_wdata_op carries store_data_ip shifted left by 8*byte-offset.
REQ-012 Load result: data_rdata_ip shifted right by 8*byte-offset; LB and LH sign-extend; LBU and LHU zero-extend; LW passes all 32 bits and sign-extends when DATA_W=64.
REQ-013 load_mem_data_op is registered on the rvalid cycle and holds its value until the next load completes.
REQ-014 lsu_done_op pulses in the cycle after the store grant or the load rvalid.
REQ-015 Load latency: accept at cycle 0, request at cycle 1, grant at cycle 1 and rvalid at cycle 2 give done and data at cycle 3.
REQ-016 An 8-bit timeout counter clears on entry to REQ, increments in REQ and WAIT_RESP, and on reaching TIMEOUT_CYC aborts with a timeout_op pulse and no done pulse.
REQ-017 Grant or rvalid arriving in the same cycle as the timeout expiry takes priority; the operation completes normally.
REQ-018 While busy, lsu_en_ip is ignored; data_rvalid_ip in IDLE or REQ is ignored.

Reset
REQ-019 On reset the FSM goes to IDLE, the counter clears, and every output is 0, including load_mem_data_op; reset asserted mid-operation abandons the operation with no done or fault pulse.

Structure
REQ-020 The extended load_store_func_code enum, the lsu_state_t enum and the NB/offset-width localparams live in CORE_PKG.
REQ-021 Byte-lane steering (REQ-010 to REQ-012) is a combinational sub-module named lsu_lane_align.

Verification
REQ-022 SW at 0x100 with data 0xDEADBEEF, grant after 2 cycles -> be=4'b1111, wdata=0xDEADBEEF, done pulse in the cycle after grant.
REQ-023 LB at 0x103 with rdata 0x80FF_FFFF -> result 0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-024 LH at 0x102 with rdata 0x8001_1234 -> result 0xFFFF8001, be=4'b1100.
REQ-025 LW at 0x101 -> misaligned_op pulse, data_req_op never high, busy stays 0.
REQ-026 TIMEOUT_CYC=4 with grant never asserted -> timeout_op pulses 4 cycles after REQ entry, return to IDLE, no done pulse; grant on the expiry cycle -> normal completion.
REQ-027 Reset asserted while in WAIT_RESP -> next cycle IDLE with all outputs 0; a later rvalid is ignored.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and helpers for the load/store unit.
// Contents:
//   load_store_func_code : memory operation encoding (loads and stores)
//   lsu_state_t          : LSU control FSM states
//   NB_*/OFF_W_*         : byte-lane count and byte-offset width per data width
//   lsu_nb / lsu_off_w   : width helpers used to size lanes from DATA_W
//   lsu_is_store / lsu_is_aligned : operation classification helpers
package core_pkg;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LH  = 3'd1,
    LW  = 3'd2,
    LBU = 3'd3,
    LHU = 3'd4,
    SB  = 3'd5,
    SH  = 3'd6,
    SW  = 3'd7
  } load_store_func_code;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_RESP = 2'd2
  } lsu_state_t;

  localparam int unsigned NB_32    = 4;
  localparam int unsigned NB_64    = 8;
  localparam int unsigned OFF_W_32 = 2;
  localparam int unsigned OFF_W_64 = 3;

  function automatic int unsigned lsu_nb(input int unsigned w);
    return (w == 64) ? NB_64 : NB_32;
  endfunction

  function automatic int unsigned lsu_off_w(input int unsigned w);
    return (w == 64) ? OFF_W_64 : OFF_W_32;
  endfunction

  function automatic logic lsu_is_store(input load_store_func_code op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  // Word alignment only looks at addr[1:0] even for 64-bit data: a word may
  // sit in either half of a doubleword.
  function automatic logic lsu_is_aligned(input load_store_func_code op,
                                          input logic [1:0] a);
    case (op)
      LH, LHU, SH: return ~a[0];
      LW, SW:      return (a == 2'b00);
      default:     return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_pipe_lane_align.sv
// lsu_lane_align: combinational byte-lane steering for the LSU.
// Ports:
//   i_op    : operation code
//   i_off   : byte offset of the access within the data word
//   i_sdata : right-aligned store data
//   i_rdata : raw memory read data
//   o_be    : byte enables for the access
//   o_wdata : store data shifted onto its byte lanes
//   o_ldata : read data shifted down and sign/zero extended
module lsu_lane_align
  import core_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  load_store_func_code             i_op,
  input  logic [lsu_off_w(DATA_W)-1:0]    i_off,
  input  logic [DATA_W-1:0]               i_sdata,
  input  logic [DATA_W-1:0]               i_rdata,
  output logic [lsu_nb(DATA_W)-1:0]       o_be,
  output logic [DATA_W-1:0]               o_wdata,
  output logic [DATA_W-1:0]               o_ldata
);

  localparam int NB    = lsu_nb(DATA_W);
  localparam int OFF_W = lsu_off_w(DATA_W);

  logic [OFF_W+2:0]   w_shamt;
  logic [NB-1:0]      w_mask;
  logic [DATA_W-1:0]  w_rsh;
  logic signed [7:0]  w_byte;
  logic signed [15:0] w_half;
  logic signed [31:0] w_word;

  assign w_shamt = {i_off, 3'b000};
  assign w_rsh   = i_rdata >> w_shamt;
  assign w_byte  = w_rsh[7:0];
  assign w_half  = w_rsh[15:0];
  assign w_word  = w_rsh[31:0];

  always_comb begin
    w_mask = '0;
    case (i_op)
      LB, LBU, SB: w_mask[0]   = 1'b1;
      LH, LHU, SH: w_mask[1:0] = 2'b11;
      default:     w_mask[3:0] = 4'hF;
    endcase
  end

  // Offsets are already known aligned, so one shift covers all access sizes.
  assign o_be    = w_mask << i_off;
  assign o_wdata = i_sdata << w_shamt;

  always_comb begin
    o_ldata = '0;
    case (i_op)
      LB:      o_ldata = DATA_W'(w_byte);
      LBU:     o_ldata = DATA_W'(w_rsh[7:0]);
      LH:      o_ldata = DATA_W'(w_half);
      LHU:     o_ldata = DATA_W'(w_rsh[15:0]);
      default: o_ldata = DATA_W'(w_word);
    endcase
  end

endmodule

// File: rtl/lsu_pipe.sv
// lsu_pipe: single-outstanding load/store unit with request/grant memory
// handshake, alignment check and response timeout.
// Ports:
//   clock, reset (sync, active-high)
//   lsu_en_ip, lsu_operator_ip, alu_valid_ip, mem_addr_ip, store_data_ip : operation issue
//   data_req_op, data_gnt_ip, data_addr_op, data_we_op, data_be_op,
//   data_wdata_op, data_rvalid_ip, data_rdata_ip                          : memory port
//   load_mem_data_op : extended load result, held until the next load completes
//   lsu_busy_op      : FSM not in IDLE
//   lsu_done_op, misaligned_op, timeout_op : one-cycle status pulses
module lsu_pipe
  import core_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          lsu_en_ip,
  input  load_store_func_code           lsu_operator_ip,
  input  logic                          alu_valid_ip,
  input  logic [DATA_W-1:0]             mem_addr_ip,
  input  logic [DATA_W-1:0]             store_data_ip,
  output logic                          data_req_op,
  input  logic                          data_gnt_ip,
  output logic [DATA_W-1:0]             data_addr_op,
  output logic                          data_we_op,
  output logic [lsu_nb(DATA_W)-1:0]     data_be_op,
  output logic [DATA_W-1:0]             data_wdata_op,
  input  logic                          data_rvalid_ip,
  input  logic [DATA_W-1:0]             data_rdata_ip,
  output logic [DATA_W-1:0]             load_mem_data_op,
  output logic                          lsu_busy_op,
  output logic                          lsu_done_op,
  output logic                          misaligned_op,
  output logic                          timeout_op
);

  localparam int         NB       = lsu_nb(DATA_W);
  localparam int         OFF_W    = lsu_off_w(DATA_W);
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

  lsu_state_t          r_state;
  load_store_func_code r_op;
  logic [DATA_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_sdata;
  logic [DATA_W-1:0]   r_ldata;
  logic [7:0]          r_cnt;
  logic                r_done;
  logic                r_misaligned;
  logic                r_timeout;

  logic                w_accept;
  logic                w_aligned;
  logic                w_in_req;
  logic                w_expire;
  logic [NB-1:0]       w_be;
  logic [DATA_W-1:0]   w_wdata;
  logic [DATA_W-1:0]   w_ldata;

  assign w_accept  = (r_state == IDLE) && lsu_en_ip && alu_valid_ip;
  assign w_aligned = lsu_is_aligned(lsu_operator_ip, mem_addr_ip[1:0]);
  assign w_in_req  = (r_state == REQ);
  // Counter value on the last permitted cycle; a handshake in this same
  // cycle still wins over the abort.
  assign w_expire  = (r_cnt == CNT_LAST);

  lsu_lane_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .i_op    (r_op),
    .i_off   (r_addr[OFF_W-1:0]),
    .i_sdata (r_sdata),
    .i_rdata (data_rdata_ip),
    .o_be    (w_be),
    .o_wdata (w_wdata),
    .o_ldata (w_ldata)
  );

  // Operation capture: data only, control comes from r_state.
  always_ff @(posedge clock) begin
    if (w_accept && w_aligned) begin
      r_op    <= lsu_operator_ip;
      r_addr  <= mem_addr_ip;
      r_sdata <= store_data_ip;
    end
  end

  // Control FSM, timeout counter, status pulses and load result.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_done       <= 1'b0;
      r_misaligned <= 1'b0;
      r_timeout    <= 1'b0;
      r_ldata      <= '0;
    end else begin
      r_done       <= 1'b0;
      r_misaligned <= 1'b0;
      r_timeout    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_aligned) begin
              r_state <= REQ;
              r_cnt   <= '0;
            end else begin
              r_misaligned <= 1'b1;
            end
          end
        end
        REQ: begin
          if (data_gnt_ip) begin
            r_cnt <= r_cnt + 8'd1;
            if (lsu_is_store(r_op)) begin
              r_state <= IDLE;
              r_done  <= 1'b1;
            end else begin
              r_state <= WAIT_RESP;
            end
          end else if (w_expire) begin
            r_state   <= IDLE;
            r_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        WAIT_RESP: begin
          if (data_rvalid_ip) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
            r_ldata <= w_ldata;
          end else if (w_expire) begin
            r_state   <= IDLE;
            r_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Memory request outputs are gated so the bus reads zero outside REQ.
  assign data_req_op      = w_in_req;
  assign data_addr_op     = w_in_req ? {r_addr[DATA_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign data_we_op       = w_in_req && lsu_is_store(r_op);
  assign data_be_op       = w_in_req ? w_be : '0;
  assign data_wdata_op    = w_in_req ? w_wdata : '0;
  assign load_mem_data_op = r_ldata;
  assign lsu_busy_op      = (r_state != IDLE);
  assign lsu_done_op      = r_done;
  assign misaligned_op    = r_misaligned;
  assign timeout_op       = r_timeout;

endmodule

// File: tb/tb_lsu_pipe.sv
module tb_lsu_pipe;
  import core_pkg::*;

  logic                clock = 1'b0;
  logic                reset;
  logic                lsu_en_ip;
  load_store_func_code lsu_operator_ip;
  logic                alu_valid_ip;
  logic [31:0]         mem_addr_ip;
  logic [31:0]         store_data_ip;
  logic                data_req_op;
  logic                data_gnt_ip;
  logic [31:0]         data_addr_op;
  logic                data_we_op;
  logic [3:0]          data_be_op;
  logic [31:0]         data_wdata_op;
  logic                data_rvalid_ip;
  logic [31:0]         data_rdata_ip;
  logic [31:0]         load_mem_data_op;
  logic                lsu_busy_op;
  logic                lsu_done_op;
  logic                misaligned_op;
  logic                timeout_op;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] ldata;
  } exp_t;

  exp_t q_exp[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  lsu_pipe #(.DATA_W(32), .TIMEOUT_CYC(4)) dut (
    .clock(clock), .reset(reset), .lsu_en_ip(lsu_en_ip), .lsu_operator_ip(lsu_operator_ip),
    .alu_valid_ip(alu_valid_ip), .mem_addr_ip(mem_addr_ip), .store_data_ip(store_data_ip),
    .data_req_op(data_req_op), .data_gnt_ip(data_gnt_ip), .data_addr_op(data_addr_op),
    .data_we_op(data_we_op), .data_be_op(data_be_op), .data_wdata_op(data_wdata_op),
    .data_rvalid_ip(data_rvalid_ip), .data_rdata_ip(data_rdata_ip),
    .load_mem_data_op(load_mem_data_op), .lsu_busy_op(lsu_busy_op), .lsu_done_op(lsu_done_op),
    .misaligned_op(misaligned_op), .timeout_op(timeout_op)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_accept(input load_store_func_code op, input logic [31:0] a,
                              input logic [31:0] d);
    lsu_en_ip = 1'b1; alu_valid_ip = 1'b1;
    lsu_operator_ip = op; mem_addr_ip = a; store_data_ip = d;
    tick();
    lsu_en_ip = 1'b0; alu_valid_ip = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    n_tests++; if (lsu_busy_op !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", lsu_busy_op); end
    n_tests++; if ({data_req_op, data_we_op, lsu_done_op, misaligned_op, timeout_op} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 00000", {data_req_op, data_we_op, lsu_done_op, misaligned_op, timeout_op}); end
    n_tests++; if ({data_addr_op, data_be_op, data_wdata_op, load_mem_data_op} !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h/%h/%h/%h expected zeros", data_addr_op, data_be_op, data_wdata_op, load_mem_data_op); end
  endtask

  task automatic test_store_word();
    exp_t e;
    q_exp.push_back('{addr: 32'h100, be: 4'b1111, wdata: 32'hDEADBEEF, ldata: 32'h0});
    drive_accept(SW, 32'h100, 32'hDEADBEEF);
    for (int k = 0; k < 2; k++) begin
      n_tests++; if (data_req_op !== 1'b1 || data_we_op !== 1'b1) begin
        n_fail++; $display("FAIL sw_req_hold%0d: got req=%b we=%b expected 1/1", k, data_req_op, data_we_op); end
      tick();
    end
    e = q_exp.pop_front();
    n_tests++; if (data_addr_op !== e.addr || data_be_op !== e.be || data_wdata_op !== e.wdata) begin
      n_fail++; $display("FAIL sw_bus: got %h/%b/%h expected %h/%b/%h", data_addr_op, data_be_op, data_wdata_op, e.addr, e.be, e.wdata); end
    data_gnt_ip = 1'b1;
    tick();
    data_gnt_ip = 1'b0;
    n_tests++; if (lsu_done_op !== 1'b1 || lsu_busy_op !== 1'b0 || data_req_op !== 1'b0) begin
      n_fail++; $display("FAIL sw_done: got done=%b busy=%b req=%b expected 1/0/0", lsu_done_op, lsu_busy_op, data_req_op); end
    tick();
    n_tests++; if (lsu_done_op !== 1'b0) begin n_fail++; $display("FAIL sw_done_pulse: got %b expected 0", lsu_done_op); end
  endtask

  task automatic test_store_lanes();
    load_store_func_code t_op[3] = '{SB, SH, SB};
    logic [31:0] t_a[3] = '{32'h201, 32'h302, 32'h403};
    logic [31:0] t_d[3] = '{32'h000000AB, 32'h00001234, 32'h00000055};
    logic [3:0]  t_be[3] = '{4'b0010, 4'b1100, 4'b1000};
    logic [31:0] t_w[3] = '{32'h0000AB00, 32'h12340000, 32'h55000000};
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      q_exp.push_back('{addr: t_a[i] & 32'hFFFF_FFFC, be: t_be[i], wdata: t_w[i], ldata: 32'h0});
      drive_accept(t_op[i], t_a[i], t_d[i]);
      e = q_exp.pop_front();
      n_tests++; if (data_req_op !== 1'b1 || data_addr_op !== e.addr || data_be_op !== e.be || data_wdata_op !== e.wdata) begin
        n_fail++; $display("FAIL store_lane%0d: got %b/%h/%b/%h expected 1/%h/%b/%h", i, data_req_op, data_addr_op, data_be_op, data_wdata_op, e.addr, e.be, e.wdata); end
      data_gnt_ip = 1'b1; tick(); data_gnt_ip = 1'b0;
      n_tests++; if (lsu_done_op !== 1'b1) begin n_fail++; $display("FAIL store_lane_done%0d: got %b expected 1", i, lsu_done_op); end
      tick();
    end
  endtask

  task automatic test_load_extend();
    load_store_func_code t_op[6] = '{LB, LBU, LH, LHU, LW, LB};
    logic [31:0] t_a[6]  = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100, 32'h101};
    logic [31:0] t_rd[6] = '{32'h80FFFFFF, 32'h80FFFFFF, 32'h80011234, 32'h80011234, 32'hCAFEF00D, 32'h00007F00};
    logic [3:0]  t_be[6] = '{4'b1000, 4'b1000, 4'b1100, 4'b1100, 4'b1111, 4'b0010};
    logic [31:0] t_r[6]  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001, 32'hCAFEF00D, 32'h0000007F};
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      q_exp.push_back('{addr: t_a[i] & 32'hFFFF_FFFC, be: t_be[i], wdata: 32'h0, ldata: t_r[i]});
      drive_accept(t_op[i], t_a[i], 32'h0);
      e = q_exp.pop_front();
      n_tests++; if (data_req_op !== 1'b1 || data_we_op !== 1'b0 || data_addr_op !== e.addr || data_be_op !== e.be) begin
        n_fail++; $display("FAIL load_req%0d: got %b/%b/%h/%b expected 1/0/%h/%b", i, data_req_op, data_we_op, data_addr_op, data_be_op, e.addr, e.be); end
      data_gnt_ip = 1'b1; tick(); data_gnt_ip = 1'b0;
      n_tests++; if (data_req_op !== 1'b0 || lsu_busy_op !== 1'b1 || lsu_done_op !== 1'b0) begin
        n_fail++; $display("FAIL load_wait%0d: got req=%b busy=%b done=%b expected 0/1/0", i, data_req_op, lsu_busy_op, lsu_done_op); end
      data_rvalid_ip = 1'b1; data_rdata_ip = t_rd[i];
      tick();
      data_rvalid_ip = 1'b0; data_rdata_ip = 32'h5A5A5A5A;
      n_tests++; if (lsu_done_op !== 1'b1 || load_mem_data_op !== e.ldata) begin
        n_fail++; $display("FAIL load_result%0d: got done=%b data=%h expected 1/%h", i, lsu_done_op, load_mem_data_op, e.ldata); end
      tick();
      n_tests++; if (lsu_done_op !== 1'b0 || load_mem_data_op !== e.ldata) begin
        n_fail++; $display("FAIL load_hold%0d: got done=%b data=%h expected 0/%h", i, lsu_done_op, load_mem_data_op, e.ldata); end
    end
  endtask

  task automatic test_misaligned();
    load_store_func_code t_op[3] = '{LW, LH, SW};
    logic [31:0] t_a[3] = '{32'h101, 32'h103, 32'h102};
    logic saw_req;
    for (int i = 0; i < 3; i++) begin
      drive_accept(t_op[i], t_a[i], 32'h11223344);
      saw_req = data_req_op;
      n_tests++; if (misaligned_op !== 1'b1 || lsu_busy_op !== 1'b0) begin
        n_fail++; $display("FAIL misaligned_pulse%0d: got mis=%b busy=%b expected 1/0", i, misaligned_op, lsu_busy_op); end
      for (int k = 0; k < 3; k++) begin
        tick();
        saw_req = saw_req | data_req_op | lsu_busy_op | misaligned_op;
      end
      n_tests++; if (saw_req !== 1'b0) begin n_fail++; $display("FAIL misaligned_quiet%0d: got %b expected 0", i, saw_req); end
    end
  endtask

  task automatic test_ignore_while_busy();
    exp_t e;
    q_exp.push_back('{addr: 32'h104, be: 4'b1111, wdata: 32'h0, ldata: 32'h600DF00D});
    drive_accept(LW, 32'h104, 32'h0);
    // rvalid during REQ must not complete the load
    data_rvalid_ip = 1'b1; data_rdata_ip = 32'hBAD0BAD0;
    tick();
    data_rvalid_ip = 1'b0;
    n_tests++; if (data_req_op !== 1'b1 || lsu_done_op !== 1'b0) begin
      n_fail++; $display("FAIL rvalid_in_req: got req=%b done=%b expected 1/0", data_req_op, lsu_done_op); end
    data_gnt_ip = 1'b1; tick(); data_gnt_ip = 1'b0;
    drive_accept(SW, 32'h300, 32'hFFFFFFFF);
    n_tests++; if (data_req_op !== 1'b0 || lsu_busy_op !== 1'b1) begin
      n_fail++; $display("FAIL en_while_busy: got req=%b busy=%b expected 0/1", data_req_op, lsu_busy_op); end
    e = q_exp.pop_front();
    data_rvalid_ip = 1'b1; data_rdata_ip = 32'h600DF00D; tick(); data_rvalid_ip = 1'b0;
    n_tests++; if (lsu_done_op !== 1'b1 || load_mem_data_op !== e.ldata) begin
      n_fail++; $display("FAIL busy_load_result: got %b/%h expected 1/%h", lsu_done_op, load_mem_data_op, e.ldata); end
    tick();
    n_tests++; if (lsu_busy_op !== 1'b0 || data_req_op !== 1'b0) begin
      n_fail++; $display("FAIL en_dropped: got busy=%b req=%b expected 0/0", lsu_busy_op, data_req_op); end
  endtask

  task automatic test_timeout();
    logic any_done;
    // store never granted: REQ entered at E, pulse at E+4
    drive_accept(SW, 32'h200, 32'h1);
    any_done = 1'b0;
    for (int k = 0; k < 3; k++) begin tick(); any_done |= lsu_done_op | timeout_op; end
    n_tests++; if (any_done !== 1'b0 || lsu_busy_op !== 1'b1) begin
      n_fail++; $display("FAIL to_early: got pulse=%b busy=%b expected 0/1", any_done, lsu_busy_op); end
    tick();
    n_tests++; if (timeout_op !== 1'b1 || lsu_busy_op !== 1'b0 || lsu_done_op !== 1'b0) begin
      n_fail++; $display("FAIL to_store: got to=%b busy=%b done=%b expected 1/0/0", timeout_op, lsu_busy_op, lsu_done_op); end
    tick();
    n_tests++; if (timeout_op !== 1'b0 || lsu_done_op !== 1'b0) begin
      n_fail++; $display("FAIL to_pulse: got to=%b done=%b expected 0/0", timeout_op, lsu_done_op); end
    // load granted at once, rvalid never arrives
    drive_accept(LW, 32'h208, 32'h0);
    data_gnt_ip = 1'b1; tick(); data_gnt_ip = 1'b0;
    tick(); tick(); tick();
    n_tests++; if (timeout_op !== 1'b1 || lsu_busy_op !== 1'b0 || lsu_done_op !== 1'b0) begin
      n_fail++; $display("FAIL to_load: got to=%b busy=%b done=%b expected 1/0/0", timeout_op, lsu_busy_op, lsu_done_op); end
    tick();
    // grant on the expiry cycle completes normally
    drive_accept(SW, 32'h20C, 32'h2);
    tick(); tick(); tick();
    data_gnt_ip = 1'b1; tick(); data_gnt_ip = 1'b0;
    n_tests++; if (lsu_done_op !== 1'b1 || timeout_op !== 1'b0) begin
      n_fail++; $display("FAIL gnt_at_expiry: got done=%b to=%b expected 1/0", lsu_done_op, timeout_op); end
    tick();
    // rvalid on the expiry cycle completes normally
    drive_accept(LHU, 32'h212, 32'h0);
    data_gnt_ip = 1'b1; tick(); data_gnt_ip = 1'b0;
    tick(); tick();
    data_rvalid_ip = 1'b1; data_rdata_ip = 32'hBEEF0000; tick(); data_rvalid_ip = 1'b0;
    n_tests++; if (lsu_done_op !== 1'b1 || timeout_op !== 1'b0 || load_mem_data_op !== 32'h0000BEEF) begin
      n_fail++; $display("FAIL rvalid_at_expiry: got done=%b to=%b data=%h expected 1/0/0000beef", lsu_done_op, timeout_op, load_mem_data_op); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic any;
    drive_accept(LW, 32'h400, 32'h0);
    data_gnt_ip = 1'b1; tick(); data_gnt_ip = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    n_tests++; if (lsu_busy_op !== 1'b0 || load_mem_data_op !== 32'h0 || {lsu_done_op, misaligned_op, timeout_op, data_req_op} !== 4'b0) begin
      n_fail++; $display("FAIL reset_mid: got busy=%b data=%h flags=%b expected 0/0/0000", lsu_busy_op, load_mem_data_op, {lsu_done_op, misaligned_op, timeout_op, data_req_op}); end
    data_rvalid_ip = 1'b1; data_rdata_ip = 32'h12345678; tick(); data_rvalid_ip = 1'b0;
    any = lsu_done_op | lsu_busy_op;
    tick();
    any |= lsu_done_op | lsu_busy_op;
    n_tests++; if (any !== 1'b0 || load_mem_data_op !== 32'h0) begin
      n_fail++; $display("FAIL late_rvalid: got pulse=%b data=%h expected 0/0", any, load_mem_data_op); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int cyc;
    q_exp.push_back('{addr: 32'h500, be: 4'b0001, wdata: 32'h00000077, ldata: 32'h0});
    q_exp.push_back('{addr: 32'h504, be: 4'b0011, wdata: 32'h0000CDEF, ldata: 32'h0});
    drive_accept(SB, 32'h500, 32'h77);
    e = q_exp.pop_front();
    n_tests++; if (data_addr_op !== e.addr || data_be_op !== e.be || data_wdata_op !== e.wdata) begin
      n_fail++; $display("FAIL b2b_first: got %h/%b/%h expected %h/%b/%h", data_addr_op, data_be_op, data_wdata_op, e.addr, e.be, e.wdata); end
    data_gnt_ip = 1'b1; tick(); data_gnt_ip = 1'b0;
    // issue the next op in the done cycle
    drive_accept(SH, 32'h504, 32'hCDEF);
    cyc = 0;
    while (data_req_op !== 1'b1 && cyc < 10) begin tick(); cyc++; end
    e = q_exp.pop_front();
    n_tests++; if (cyc != 0 || data_addr_op !== e.addr || data_be_op !== e.be || data_wdata_op !== e.wdata) begin
      n_fail++; $display("FAIL b2b_second: got wait=%0d %h/%b/%h expected 0 %h/%b/%h", cyc, data_addr_op, data_be_op, data_wdata_op, e.addr, e.be, e.wdata); end
    data_gnt_ip = 1'b1; tick(); data_gnt_ip = 1'b0;
    n_tests++; if (lsu_done_op !== 1'b1) begin n_fail++; $display("FAIL b2b_done: got %b expected 1", lsu_done_op); end
    tick();
    n_tests++; if (q_exp.size() != 0) begin n_fail++; $display("FAIL scoreboard_left: got %0d expected 0", q_exp.size()); end
  endtask

  initial begin
    reset = 1'b1; lsu_en_ip = 1'b0; alu_valid_ip = 1'b0; lsu_operator_ip = LB;
    mem_addr_ip = '0; store_data_ip = '0; data_gnt_ip = 1'b0;
    data_rvalid_ip = 1'b0; data_rdata_ip = '0;
    test_reset();
    test_store_word();
    test_store_lanes();
    test_load_extend();
    test_misaligned();
    test_ignore_while_busy();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
